// File: rtl/dsp_sched_pkg.sv
// Shared constants, types and helpers for the round-robin DSP scheduler.
package dsp_sched_pkg;

  localparam int unsigned DSP_DATA_WIDTH = 4;
  localparam int unsigned DSP_OPND_WIDTH = 2;
  // Widest requester index supported (NUM_REQ up to 8).
  localparam int unsigned MAX_ID_WIDTH   = 3;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [MAX_ID_WIDTH-1:0]   id;
    logic [DSP_DATA_WIDTH-1:0] data;
  } rsp_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans requests from the pointer with wrap-around and
// advances the pointer past the granted requester when told to.
module rr_arbiter
  import dsp_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IdW = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IdW-1:0]     grant_idx
);

  logic [IdW-1:0] ptr_q;

  always_comb begin
    int unsigned idx;
    logic        found;
    idx       = 0;
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (32'(ptr_q) + off) % NUM_REQ;
      if (!found && req[IdW'(idx)]) begin
        found              = 1'b1;
        grant[IdW'(idx)]   = 1'b1;
        grant_idx          = IdW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (grant_idx == IdW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/dsp_rr_scheduler.sv
// Shares one registered DSP block among NUM_REQ requesters round-robin and
// collects tagged results in a response FIFO sized by issue credits.
module dsp_rr_scheduler
  import dsp_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = DSP_DATA_WIDTH,
  parameter int unsigned RSP_DEPTH  = 2,
  localparam int unsigned OPND_W    = DATA_WIDTH / 2,
  localparam int unsigned ID_W      = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OPND_W-1:0] req_a,
  input  logic [NUM_REQ*OPND_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_m,
  output logic [OPND_W-1:0]         dsp_a,
  output logic [OPND_W-1:0]         dsp_b,
  output logic                      dsp_m,
  input  logic [DATA_WIDTH-1:0]     dsp_out,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic [ID_W-1:0]           rsp_id
);

  localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               pop, issue_ok, issue, push;
  logic               inflight_q;
  logic [ID_W-1:0]    inflight_id_q;
  rsp_entry_t         mem_q [RSP_DEPTH];
  rsp_entry_t         push_entry, head;
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (issue),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign pop = rsp_valid & rsp_ready;
  // The DSP cannot stall, so every issue must already own a FIFO slot.
  assign issue_ok  = (32'(count_q) + 32'(inflight_q) - 32'(pop)) < RSP_DEPTH;
  assign req_ready = (rst || !issue_ok) ? '0 : grant;
  assign issue     = |(req_valid & req_ready);

  assign dsp_a = issue ? req_a[grant_idx*OPND_W +: OPND_W] : '0;
  assign dsp_b = issue ? req_b[grant_idx*OPND_W +: OPND_W] : '0;
  assign dsp_m = issue ? req_m[grant_idx] : 1'b0;

  assign push       = inflight_q & ~rst;
  assign push_entry = '{id: MAX_ID_WIDTH'(inflight_id_q), data: DSP_DATA_WIDTH'(dsp_out)};
  assign head       = mem_q[rd_ptr_q];

  assign rsp_valid = (count_q != '0);
  assign rsp_data  = DATA_WIDTH'(head.data);
  assign rsp_id    = ID_W'(head.id);

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      inflight_q <= issue;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    inflight_id_q <= grant_idx;
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (push) assert (count_q != CNT_W'(RSP_DEPTH));
  end

endmodule

// File: tb/tb_dsp_rr_scheduler.sv
// Bench for dsp_rr_scheduler: directed vectors, expected responses queued by
// the stimulus and popped by an independent monitor.
module tb_dsp_rr_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Two-requester instance
  logic [1:0] req_valid, req_ready, req_m;
  logic [3:0] req_a, req_b;
  logic [1:0] dsp_a, dsp_b;
  logic       dsp_m;
  logic [3:0] dsp_out, stub_out, garbage;
  logic       garbage_en;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_id;
  logic [1:0] qa, qb;
  logic       qm;

  always @(posedge clk) begin
    qa <= dsp_a;
    qb <= dsp_b;
    qm <= dsp_m;
  end
  assign stub_out = {qa, qb} ^ {4{qm}};
  assign dsp_out  = garbage_en ? garbage : stub_out;

  dsp_rr_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_m     (req_m),
    .dsp_a     (dsp_a),
    .dsp_b     (dsp_b),
    .dsp_m     (dsp_m),
    .dsp_out   (dsp_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  // Three-requester instance for pointer wrap
  logic [2:0] v3, rdy3, m3;
  logic [5:0] a3, b3;
  logic [1:0] dsp_a3, dsp_b3, qa3, qb3;
  logic       dsp_m3, qm3;
  logic [3:0] dsp_out3, rsp_data3;
  logic       rsp_valid3;
  logic [1:0] rsp_id3;

  always @(posedge clk) begin
    qa3 <= dsp_a3;
    qb3 <= dsp_b3;
    qm3 <= dsp_m3;
  end
  assign dsp_out3 = {qa3, qb3} ^ {4{qm3}};

  dsp_rr_scheduler #(.NUM_REQ(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (v3),
    .req_ready (rdy3),
    .req_a     (a3),
    .req_b     (b3),
    .req_m     (m3),
    .dsp_a     (dsp_a3),
    .dsp_b     (dsp_b3),
    .dsp_m     (dsp_m3),
    .dsp_out   (dsp_out3),
    .rsp_valid (rsp_valid3),
    .rsp_ready (1'b1),
    .rsp_data  (rsp_data3),
    .rsp_id    (rsp_id3)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] sb [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every popped response must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got id=%0d data=%b expected none", rsp_id, rsp_data);
      end else begin
        check("rsp_entry", {27'd0, rsp_id, rsp_data}, {27'd0, sb.pop_front()});
      end
    end
  end

  // One cycle: drive, check ready/dsp/rsp_valid at negedge, queue expectation.
  task automatic cyc(input logic [1:0] v, input logic [3:0] a, input logic [3:0] b,
                     input logic [1:0] m, input logic rr, input logic [1:0] exp_rdy,
                     input logic [4:0] exp_rsp, input int exp_rv);
    logic [4:0] exp_dsp;
    int g;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    req_m     = m;
    rsp_ready = rr;
    @(negedge clk);
    check("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
    if (|(v & exp_rdy) && !rst) begin
      g       = exp_rdy[1] ? 1 : 0;
      exp_dsp = {a[g*2 +: 2], b[g*2 +: 2], m[g]};
      sb.push_back(exp_rsp);
    end else begin
      exp_dsp = 5'd0;
    end
    check("dsp_in", {27'd0, dsp_a, dsp_b, dsp_m}, {27'd0, exp_dsp});
    if (exp_rv >= 0) check("rsp_valid", {31'd0, rsp_valid}, exp_rv[31:0]);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 2'b00;
    v3        = 3'b000;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [2:0] t6_v   [6] = '{3'b100, 3'b001, 3'b111, 3'b000, 3'b000, 3'b000};
  logic [2:0] t6_rdy [6] = '{3'b100, 3'b001, 3'b010, 3'b000, 3'b000, 3'b000};
  logic       t6_rv  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [5:0] t6_rsp [6] = '{6'h00, 6'h00, {2'd2, 4'b0111}, {2'd0, 4'b1000},
                             {2'd1, 4'b0000}, 6'h00};

  initial begin
    rst = 1'b1; garbage_en = 1'b0; garbage = 4'd0;
    req_valid = '0; req_a = '0; req_b = '0; req_m = '0; rsp_ready = 1'b1;
    v3 = '0; a3 = '0; b3 = '0; m3 = '0;
    @(posedge clk);
    #1;
    // Reset state: ready forced low even with requests pending
    cyc(2'b11, 4'h0, 4'h0, 2'b00, 1'b1, 2'b00, 5'd0, -1);
    rst = 1'b0;
    cyc(2'b00, 4'h0, 4'h0, 2'b00, 1'b1, 2'b00, 5'd0, 0);

    // Test 1: single op, 2-cycle latency
    cyc(2'b01, 4'b0010, 4'b0001, 2'b00, 1'b1, 2'b01, {1'b0, 4'b1001}, 0);
    cyc(2'b00, 4'h0, 4'h0, 2'b00, 1'b1, 2'b00, 5'd0, 0);
    cyc(2'b00, 4'h0, 4'h0, 2'b00, 1'b1, 2'b00, 5'd0, 1);
    cyc(2'b00, 4'h0, 4'h0, 2'b00, 1'b1, 2'b00, 5'd0, 0);

    // Test 2: contention alternates grants at full rate
    do_reset();
    for (int i = 0; i < 8; i++)
      cyc(2'b11, 4'b1110, 4'b0001, 2'b10, 1'b1, (i % 2 == 1) ? 2'b10 : 2'b01,
          (i % 2 == 1) ? {1'b1, 4'b0011} : {1'b0, 4'b1001}, -1);
    for (int i = 0; i < 3; i++) cyc(2'b00, 4'h0, 4'h0, 2'b00, 1'b1, 2'b00, 5'd0, -1);

    // Test 3: backpressure limits accepts to FIFO credits
    do_reset();
    cyc(2'b01, 4'b0000, 4'b0001, 2'b00, 1'b0, 2'b01, {1'b0, 4'b0001}, 0);
    cyc(2'b01, 4'b0001, 4'b0010, 2'b00, 1'b0, 2'b01, {1'b0, 4'b0110}, 0);
    cyc(2'b01, 4'b0010, 4'b0011, 2'b00, 1'b0, 2'b00, 5'd0, 1);
    cyc(2'b01, 4'b0010, 4'b0011, 2'b00, 1'b0, 2'b00, 5'd0, 1);
    @(negedge clk);
    check("bp_ready", {30'd0, req_ready}, 32'd0);
    check("bp_head", {28'd0, rsp_data}, 32'b0001);
    @(posedge clk);
    #1;
    cyc(2'b01, 4'b0010, 4'b0011, 2'b00, 1'b1, 2'b01, {1'b0, 4'b1011}, 1);
    cyc(2'b01, 4'b0011, 4'b0000, 2'b00, 1'b1, 2'b01, {1'b0, 4'b1100}, 1);
    cyc(2'b01, 4'b0000, 4'b0000, 2'b01, 1'b1, 2'b01, {1'b0, 4'b1111}, 1);
    for (int i = 0; i < 4; i++) cyc(2'b00, 4'h0, 4'h0, 2'b00, 1'b1, 2'b00, 5'd0, -1);

    // Test 4: reset while an op is in flight discards it
    do_reset();
    cyc(2'b01, 4'b0001, 4'b0001, 2'b00, 1'b1, 2'b01, {1'b0, 4'b0101}, 0);
    void'(sb.pop_back());
    rst = 1'b1;
    cyc(2'b11, 4'b0011, 4'b1001, 2'b00, 1'b1, 2'b00, 5'd0, -1);
    rst = 1'b0;
    cyc(2'b11, 4'b0011, 4'b1001, 2'b00, 1'b1, 2'b01, {1'b0, 4'b1101}, 0);
    cyc(2'b10, 4'b0011, 4'b1001, 2'b00, 1'b1, 2'b10, {1'b1, 4'b0010}, 0);
    cyc(2'b00, 4'h0, 4'h0, 2'b00, 1'b1, 2'b00, 5'd0, 1);
    cyc(2'b00, 4'h0, 4'h0, 2'b00, 1'b1, 2'b00, 5'd0, 1);
    cyc(2'b00, 4'h0, 4'h0, 2'b00, 1'b1, 2'b00, 5'd0, 0);

    // Test 5: idle DSP inputs, garbage on dsp_out is ignored
    do_reset();
    garbage_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      garbage = 4'(i * 7 + 5);
      cyc(2'b00, 4'b1111, 4'b1111, 2'b11, 1'b1, 2'b00, 5'd0, 0);
    end
    garbage_en = 1'b0;

    // Test 6: three requesters, pointer wraps 2 -> 0 then lands on 1
    do_reset();
    a3 = 6'b01_11_10;
    b3 = 6'b11_11_00;
    m3 = 3'b010;
    for (int i = 0; i < 6; i++) begin
      v3 = t6_v[i];
      @(negedge clk);
      check("wrap_ready", {29'd0, rdy3}, {29'd0, t6_rdy[i]});
      check("wrap_rsp_valid", {31'd0, rsp_valid3}, {31'd0, t6_rv[i]});
      if (t6_rv[i]) check("wrap_rsp", {26'd0, rsp_id3, rsp_data3}, {26'd0, t6_rsp[i]});
      @(posedge clk);
      #1;
    end

    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
